// File: rtl/serializer_piso.sv
// Parallel-in/serial-out stage feeding the serial sequence detector.
// Optional macro SERIALIZER_PARITY_EN appends one even-parity bit to every word.
module serializer_piso #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic               x_q, x_d;
  logic               bv_q, bv_d;
  logic               wd_q, wd_d;
  logic               busy_q, busy_d;
`ifdef SERIALIZER_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic               accept;
  logic               first_bit;
  logic               next_bit;
  logic [WIDTH-1:0]   sr_load;
  logic [WIDTH-1:0]   sr_shift;

  // The first bit goes straight to x_out on accept; the register keeps the rest.
  assign first_bit = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
  assign sr_load   = (MSB_FIRST != 0) ? {data_in[WIDTH-2:0], 1'b0}
                                      : {1'b0, data_in[WIDTH-1:1]};
  assign next_bit  = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
  assign sr_shift  = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, sr_q[WIDTH-1:1]};

  // Ready is open when idle or on the final slot of a word.
  always_comb begin
    load_ready = 1'b0;
    unique case (state_q)
      S_IDLE:   load_ready = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      S_SHIFT:  load_ready = 1'b0;
      S_PARITY: load_ready = 1'b1;
`else
      S_SHIFT:  load_ready = (cnt_q == LAST);
`endif
      default:  load_ready = 1'b0;
    endcase
  end

  assign accept = load_valid && load_ready;

  // Next-state and registered output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    x_d      = 1'b0;
    bv_d     = 1'b0;
    wd_d     = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          sr_d    = sr_load;
          x_d     = first_bit;
          bv_d    = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end

      S_SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
          sr_d  = sr_shift;
          x_d   = next_bit;
          bv_d  = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          wd_d  = 1'b0;
`else
          wd_d  = (cnt_d == LAST);
`endif
        end else begin
`ifdef SERIALIZER_PARITY_EN
          state_d = S_PARITY;
          x_d     = parity_q;
          bv_d    = 1'b1;
          wd_d    = 1'b1;
`else
          if (accept) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            sr_d    = sr_load;
            x_d     = first_bit;
            bv_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
`endif
        end
      end

`ifdef SERIALIZER_PARITY_EN
      S_PARITY: begin
        if (accept) begin
          state_d  = S_SHIFT;
          cnt_d    = '0;
          sr_d     = sr_load;
          x_d      = first_bit;
          bv_d     = 1'b1;
          parity_d = ^data_in;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sr_d    = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset overrides any accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      x_q      <= 1'b0;
      bv_q     <= 1'b0;
      wd_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      x_q      <= x_d;
      bv_q     <= bv_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign x_out     = x_q;
  assign bit_valid = bv_q;
  assign word_done = wd_q;
  assign busy      = busy_q;

endmodule
